serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor. It is the inverse-operation counterpart to the team's combinational adder. It accepts a WIDTH-bit minuend and subtrahend on a start strobe, computes the difference LSB-first with one full-subtractor cell and a borrow flop, and presents the result with a one-cycle done pulse. It is intended for area-constrained datapaths where one subtract per WIDTH+1 cycles is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
minuend_a  input  WIDTH  minuend, captured on accepted start
subtrahend_b  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while the serial computation runs
done  output  1  one-cycle pulse; result valid
difference_c  output  WIDTH  minuend_a - subtrahend_b mod 2^WIDTH
borrow_out  output  1  final borrow (1 when unsigned minuend < subtrahend)

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, difference_c=0, borrow_out=0. Internal shift registers, borrow flop and bit counter are all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when start=1 at an edge, latch the operands into shift registers A and B, clear the borrow flop, set count=0, and go to SHIFT.
- SHIFT (busy=1): each edge processes bit a=A[0], b=B[0], br=borrow.
  - d = a^b^br
  - br_next = (~a&b) | (~(a^b)&br)
  - d shifts into the MSB of result register R.
  - A and B shift right, and count increments.
  - After the WIDTH-th bit (count==WIDTH-1 at the edge), go to DONE.
  - On that same edge, copy the completed R to difference_c and br_next to borrow_out.
- DONE (busy=0, done=1 for exactly one cycle): an accepted start in this state behaves as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: start sampled at edge E0. Bits are processed at edges E1..E_WIDTH. done is high during the cycle following E_WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1: ignored. Operand inputs are don't-care after capture.
- difference_c and borrow_out hold their last result until the next completion. They never show partial values.
- Arithmetic: difference_c equals (minuend_a - subtrahend_b) mod 2^WIDTH. borrow_out equals (minuend_a < subtrahend_b) unsigned.
- rst asserted mid-operation: everything returns immediately to reset values. No done pulse is emitted for the aborted operation.

Optional Feature:
SUB_OVERFLOW_EN. When defined, the block adds output port overflow (1 bit).
- overflow is the signed two's-complement overflow: (a_msb != b_msb) && (d_msb != a_msb), using the captured operand MSBs and the result MSB.
- It is registered alongside difference_c and holds until the next completion. Reset value is 0.
- When not defined, the port and its logic are absent.

Test Plan:
- WIDTH=8: start with a=5, b=3 -> done exactly 9 cycles after start edge, difference_c=0x02, borrow_out=0, busy high for 8 cycles.
- a=3, b=5 -> difference_c=0xFE, borrow_out=1. With SUB_OVERFLOW_EN: overflow=0.
- a=0x80, b=0x01 -> difference_c=0x7F, borrow_out=0. With SUB_OVERFLOW_EN: overflow=1.
- Exhaustive 4-bit run (WIDTH=4, all 256 pairs, start issued in the DONE cycle for back-to-back) -> every result matches (a-b) mod 16 and borrow matches a<b. No idle gaps between operations.
- Start a=9, b=4; pulse start with a=1, b=1 at cycle 3 -> second start ignored, result 0x05, single done pulse.
- Start a=10, b=7; assert rst at cycle 4 -> outputs 0 immediately, no done pulse. A fresh start a=7, b=7 afterwards -> difference_c=0, borrow_out=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Request/result bus of serial_subtractor.
// Optional SUB_OVERFLOW_EN adds the signed-overflow result flag.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] minuend_a;
    logic [WIDTH-1:0] subtrahend_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference_c;
    logic             borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic             overflow;

    modport master (
        output start, minuend_a, subtrahend_b,
        input  busy, done, difference_c, borrow_out, overflow
    );
    modport slave (
        input  start, minuend_a, subtrahend_b,
        output busy, done, difference_c, borrow_out, overflow
    );
`else
    modport master (
        output start, minuend_a, subtrahend_b,
        input  busy, done, difference_c, borrow_out
    );
    modport slave (
        input  start, minuend_a, subtrahend_b,
        output busy, done, difference_c, borrow_out
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a
// borrow flop, LSB first, result published with a one-cycle done pulse.
// Optional SUB_OVERFLOW_EN adds a registered signed-overflow flag.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             bit_d;
    logic             br_next;
`ifdef SUB_OVERFLOW_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    // State, datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_OVERFLOW_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Full-subtractor cell on the current LSBs
    always_comb begin
        bit_d   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state: operand capture, serial shift, result publish
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_OVERFLOW_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.minuend_a;
                    b_d     = bus.subtrahend_b;
                    r_d     = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SUB_OVERFLOW_EN
                    amsb_d  = bus.minuend_a[WIDTH-1];
                    bmsb_d  = bus.subtrahend_b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                r_d   = {bit_d, r_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = {bit_d, r_q[WIDTH-1:1]};
                    bout_d  = br_next;
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = (amsb_q != bmsb_q) && (bit_d != amsb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy         = (state_q == SHIFT);
    assign bus.done         = (state_q == DONE);
    assign bus.difference_c = diff_q;
    assign bus.borrow_out   = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign bus.overflow     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (8-bit and 4-bit instances).
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // model of the last published 8-bit result
    int unsigned last_d8 = 0;
    int unsigned last_b8 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_diff(input int unsigned a, input int unsigned b, input int unsigned w);
        return (a + (1 << w) - b) % (1 << w);
    endfunction

    function automatic int unsigned ref_borrow(input int unsigned a, input int unsigned b);
        return (a < b) ? 1 : 0;
    endfunction

    function automatic int unsigned ref_ovf(input int unsigned a, input int unsigned b, input int unsigned w);
        int sa, sb, sd;
        sa = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
        sb = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
        sd = sa - sb;
        return (sd > (1 << (w - 1)) - 1 || sd < -(1 << (w - 1))) ? 1 : 0;
    endfunction

    // one 8-bit operation: latency, busy length, hold, result, pulse width
    task automatic op8(input int unsigned a, input int unsigned b);
        int unsigned k;
        int unsigned nbusy;
        logic [31:0] va;
        logic [31:0] vb;
        va = a;
        vb = b;
        k = 0;
        nbusy = 0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.minuend_a = va[7:0];
        bus8.subtrahend_b = vb[7:0];
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus8.start = 1'b0;
                bus8.minuend_a = 8'($urandom);
                bus8.subtrahend_b = 8'($urandom);
                check("hold_diff8", 32'(bus8.difference_c), last_d8);
                check("hold_borrow8", 32'(bus8.borrow_out), last_b8);
            end
            if (bus8.busy) nbusy++;
        end while (!bus8.done && k < 20);
        check("latency8", k, 9);
        check("busy_len8", nbusy, 8);
        check("diff8", 32'(bus8.difference_c), ref_diff(a, b, 8));
        check("borrow8", 32'(bus8.borrow_out), ref_borrow(a, b));
`ifdef SUB_OVERFLOW_EN
        check("ovf8", 32'(bus8.overflow), ref_ovf(a, b, 8));
`endif
        last_d8 = ref_diff(a, b, 8);
        last_b8 = ref_borrow(a, b);
        @(negedge clk);
        check("done_pulse8", 32'(bus8.done), 0);
    endtask

    int unsigned k;
    int unsigned ndone;
    int unsigned seen_diff;
    int unsigned pa;
    int unsigned pb;

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.minuend_a = '0; bus8.subtrahend_b = '0;
        bus4.start = 1'b0; bus4.minuend_a = '0; bus4.subtrahend_b = '0;
        #12;
        check("rst_busy8", 32'(bus8.busy), 0);
        check("rst_done8", 32'(bus8.done), 0);
        check("rst_diff8", 32'(bus8.difference_c), 0);
        check("rst_borrow8", 32'(bus8.borrow_out), 0);
        check("rst_busy4", 32'(bus4.busy), 0);
        check("rst_diff4", 32'(bus4.difference_c), 0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        op8(5, 3);
        op8(3, 5);
        op8(8'h80, 8'h01);
        op8(0, 0);
        op8(8'hFF, 8'hFF);
        op8(0, 8'hFF);
        op8(8'h7F, 8'h80);

        // randomized cases
        for (int i = 0; i < 24; i++) begin
            op8($urandom_range(0, 255), $urandom_range(0, 255));
        end

        // start while busy is ignored
        ndone = 0;
        seen_diff = 0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.minuend_a = 8'd9; bus8.subtrahend_b = 8'd4;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus8.start = 1'b0;
            if (c == 3) begin
                bus8.start = 1'b1; bus8.minuend_a = 8'd1; bus8.subtrahend_b = 8'd1;
            end
            if (c == 4) bus8.start = 1'b0;
            if (bus8.done) begin
                ndone++;
                seen_diff = 32'(bus8.difference_c);
            end
        end
        check("ignored_start_ndone", ndone, 1);
        check("ignored_start_diff", seen_diff, 5);
        check("ignored_start_idle", 32'(bus8.busy), 0);

        // reset mid-operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.minuend_a = 8'd10; bus8.subtrahend_b = 8'd7;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus8.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus8.busy), 0);
        check("midrst_done", 32'(bus8.done), 0);
        check("midrst_diff", 32'(bus8.difference_c), 0);
        check("midrst_borrow", 32'(bus8.borrow_out), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        last_d8 = 0;
        last_b8 = 0;
        op8(7, 7);

        // exhaustive 4-bit, back-to-back with start in the done cycle
        @(negedge clk);
        bus4.start = 1'b1; bus4.minuend_a = 4'd0; bus4.subtrahend_b = 4'd0;
        for (int i = 0; i < 256; i++) begin
            pa = i / 16;
            pb = i % 16;
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) bus4.start = 1'b0;
            end while (!bus4.done && k < 12);
            check("gap4", k, 5);
            check("diff4", 32'(bus4.difference_c), ref_diff(pa, pb, 4));
            check("borrow4", 32'(bus4.borrow_out), ref_borrow(pa, pb));
`ifdef SUB_OVERFLOW_EN
            check("ovf4", 32'(bus4.overflow), ref_ovf(pa, pb, 4));
`endif
            if (i < 255) begin
                bus4.start = 1'b1;
                bus4.minuend_a = 4'((i + 1) / 16);
                bus4.subtrahend_b = 4'((i + 1) % 16);
            end
        end
        @(negedge clk);
        check("done_pulse4", 32'(bus4.done), 0);
        check("final_diff4", 32'(bus4.difference_c), ref_diff(15, 15, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
